// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: memory handshakes, strobes and status of the multicycle sequencer
interface multicycle_sequencer_if;
  logic [6:0] opc;
  logic imem_ready, dmem_ready;
  logic imem_req, ir_wen, dmem_req, dmem_we, rf_wen, pc_wen;
  logic [2:0] state;
  logic illegal, bus_err;
  logic [31:0] instret;
  modport master (
    output opc, imem_ready, dmem_ready,
    input imem_req, ir_wen, dmem_req, dmem_we, rf_wen, pc_wen, state, illegal, bus_err, instret
  );
  modport slave (
    input opc, imem_ready, dmem_ready,
    output imem_req, ir_wen, dmem_req, dmem_we, rf_wen, pc_wen, state, illegal, bus_err, instret
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/execute/memory/writeback control FSM with bus timeout and retire counter
module multicycle_sequencer (
  input logic clk,
  input logic rst,
  multicycle_sequencer_if.slave bus
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;
  state_t st;
  logic [3:0] wait_cnt;
  logic illegal_q, bus_err_q;
  logic [31:0] instret_q;
  logic is_load, is_store, is_branch, legal;
  assign is_load = bus.opc == 7'b0000011;
  assign is_store = bus.opc == 7'b0100011;
  assign is_branch = bus.opc == 7'b1100011;
  assign legal = is_load | is_store | is_branch | bus.opc inside {7'b0110011, 7'b0010011, 7'b0010111, 7'b0110111, 7'b1101111, 7'b1100111};
  // Strobes depend on ready inputs within the same cycle, so they stay combinational.
  assign bus.imem_req = st == FETCH;
  assign bus.ir_wen = st == FETCH && bus.imem_ready;
  assign bus.dmem_req = st == MEMORY;
  assign bus.dmem_we = st == MEMORY && is_store;
  assign bus.rf_wen = st == WRITEBACK;
  assign bus.pc_wen = st == WRITEBACK || (st == EXECUTE && is_branch) || (st == MEMORY && is_store && bus.dmem_ready);
  assign bus.state = st;
  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
  assign bus.instret = instret_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
      wait_cnt <= '0;
    end else begin
      if (bus.pc_wen) instret_q <= instret_q + 32'd1;
      case (st)
        FETCH: if (bus.imem_ready) st <= DECODE;
        DECODE: begin
          st <= legal ? EXECUTE : HALT;
          if (!legal) illegal_q <= 1'b1;
        end
        EXECUTE: begin
          wait_cnt <= '0;
          st <= (is_load || is_store) ? MEMORY : is_branch ? FETCH : WRITEBACK;
        end
        MEMORY: begin
          if (bus.dmem_ready) st <= is_store ? FETCH : WRITEBACK;
          else begin
            wait_cnt <= wait_cnt + 4'd1;
            if (wait_cnt == 4'd15) begin
              st <= HALT;
              bus_err_q <= 1'b1;
            end
          end
        end
        WRITEBACK: st <= FETCH;
        default: st <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: random instruction stream scored against a per-instruction latency/strobe model
module tb_multicycle_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  multicycle_sequencer_if bus();
  multicycle_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;
  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0010111, 7'b0110111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};
  // kind: 0 retire, 1 illegal halt, 2 bus timeout halt, 3 reset during MEMORY
  typedef struct {int kind; int lat; int mem; bit we; bit rf; int fetch;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [31:0] exp_instret = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  function automatic bit is_legal(logic [6:0] o);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(logic [6:0] o, int di, int m, int abort_at, bit preload);
    exp_t e;
    bit mem_op;
    int n;
    mem_op = o == OP_LOAD || o == OP_STORE;
    e.fetch = di + 1;
    e.we = o == OP_STORE;
    e.mem = mem_op ? (m == 0 ? 16 : m) : 0;
    e.rf = is_legal(o) && o != OP_STORE && o != OP_BRANCH;
    if (!is_legal(o)) begin e.kind = 1; e.lat = di + 2; end
    else if (abort_at >= 0) begin e.kind = 3; e.lat = abort_at; end
    else if (mem_op && m == 0) begin e.kind = 2; e.lat = di + 19; end
    else if (o == OP_BRANCH) begin e.kind = 0; e.lat = e.fetch + 2; end
    else if (o == OP_STORE) begin e.kind = 0; e.lat = e.fetch + 2 + m; end
    else if (o == OP_LOAD) begin e.kind = 0; e.lat = e.fetch + 3 + m; end
    else begin e.kind = 0; e.lat = e.fetch + 3; end
    sb.push_back(e);
    bus.opc = o;
    n = e.kind == 0 ? e.lat : e.lat + 1;
    for (int t = 0; t < n; t++) begin
      if (e.kind == 3 && t == abort_at) break;
      if (preload && t == 0) begin
        force dut.instret_q = 32'hFFFF_FFFF;
        exp_instret = 32'hFFFF_FFFF;
      end
      if (preload && t == 1) release dut.instret_q;
      bus.imem_ready = t < di ? 1'b0 : t == di ? 1'b1 : 1'($urandom_range(0, 1));
      bus.dmem_ready = t < di + 3 ? 1'($urandom_range(0, 1)) : (mem_op && m != 0 && t == di + 2 + m);
      step();
    end
    if (e.kind != 0) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
    end
  endtask

  initial begin
    int cnt = 0, n_if = 0, n_ir = 0, n_dm = 0, n_we = 0, n_rf = 0;
    bit halted = 0, post = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (sb.size() > 0 && sb[0].kind == 3) begin
          e = sb.pop_front();
          chk("abort_dmem_req", 32'(bus.dmem_req), 32'd1);
          chk("abort_state", 32'(bus.state), 32'd3);
          chk("abort_cycle", cnt, e.lat);
        end
        cnt = 0; n_if = 0; n_ir = 0; n_dm = 0; n_we = 0; n_rf = 0;
        halted = 0; post = 1; exp_instret = '0;
      end else begin
        if (post) begin
          chk("rst_state", 32'(bus.state), 32'd0);
          chk("rst_flags", 32'({bus.illegal, bus.bus_err}), 32'd0);
          chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
          post = 0;
        end
        n_if += int'(bus.imem_req);
        n_ir += int'(bus.ir_wen);
        n_dm += int'(bus.dmem_req);
        n_we += int'(bus.dmem_we);
        n_rf += int'(bus.rf_wen);
        chk("instret", bus.instret, exp_instret);
        if (bus.pc_wen) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL pc_wen_unexpected got 1 want 0 at cycle %0d", cnt);
          end else begin
            e = sb.pop_front();
            chk("retire_kind", e.kind, 32'd0);
            chk("retire_latency", cnt + 1, e.lat);
            chk("fetch_cycles", n_if, e.fetch);
            chk("ir_wen_count", n_ir, 32'd1);
            chk("dmem_req_cycles", n_dm, e.mem);
            chk("dmem_we_cycles", n_we, e.we ? e.mem : 0);
            chk("rf_wen_count", n_rf, 32'(e.rf));
            chk("rf_with_pc", 32'(bus.rf_wen), 32'(e.rf));
          end
          exp_instret = exp_instret + 32'd1;
          cnt = 0; n_if = 0; n_ir = 0; n_dm = 0; n_we = 0; n_rf = 0;
        end else if (bus.state == 3'd5 && !halted) begin
          halted = 1;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL halt_unexpected got state 5 want no halt at cycle %0d", cnt);
          end else begin
            e = sb.pop_front();
            chk("halt_kind_nonretire", 32'(e.kind == 0), 32'd0);
            chk("halt_cycle", cnt, e.lat);
            chk("illegal", 32'(bus.illegal), 32'(e.kind == 1));
            chk("bus_err", 32'(bus.bus_err), 32'(e.kind == 2));
            chk("halt_strobes", 32'({bus.imem_req, bus.ir_wen, bus.dmem_req, bus.dmem_we, bus.rf_wen}), 32'd0);
            chk("halt_dmem_cycles", n_dm, e.kind == 2 ? 16 : 0);
            chk("halt_rf_count", n_rf, 32'd0);
          end
          cnt++;
        end else cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0] o;
    bus.opc = OP_R;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (3) run(OP_R, 0, 0, -1, 1'b0);
    run(OP_LOAD, 0, 3, -1, 1'b0);
    run(OP_STORE, 0, 16, -1, 1'b0);
    run(OP_STORE, 1, 0, -1, 1'b0);
    run(7'b1111111, 0, 0, -1, 1'b0);
    run(OP_BRANCH, 2, 0, -1, 1'b1);
    run(OP_R, 0, 0, -1, 1'b0);
    run(OP_LOAD, 0, 0, 4, 1'b0);
    repeat (200) begin
      if ($urandom_range(0, 99) < 5) begin
        o = 7'($urandom);
        while (is_legal(o)) o = 7'($urandom);
      end else o = legal_ops[$urandom_range(0, 8)];
      run(o, $urandom_range(0, 3), $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 16), -1, 1'b0);
    end
    step();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
